// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: one-hot engine states, command encodings
// ({CS_N,RAS_N,CAS_N,WE_N}) and address helpers used by the read and write engines.
package sdram_pkg;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    ACTIVATE = 6'b000010,
    WAIT_RCD = 6'b000100,
    WRITE    = 6'b001000,
    WAIT_WR  = 6'b010000,
    DONE     = 6'b100000
  } state_t;

  typedef enum logic [3:0] {
    CMD_NOP    = 4'b0111,
    CMD_ACTIVE = 4'b0011,
    CMD_READ   = 4'b0101,
    CMD_WRITE  = 4'b0100
  } cmd_t;

  // Column command address with A10 set, selecting auto-precharge.
  function automatic logic [12:0] col_addr_ap(input logic [9:0] column);
    return {2'b00, 1'b1, column};
  endfunction

endpackage

// File: rtl/sdram_wait_counter.sv
// 4-bit down-counter for SDRAM timing waits: loaded on state entry, saturates at zero,
// and flags terminal count while it holds zero.
module sdram_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] load_value,
  input  logic       load,
  output logic       tc
);

  logic [3:0] count_r;

  // Load on strobe, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != 4'd0) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == 4'd0);

endmodule

// File: rtl/sdram_write.sv
// Single-word SDRAM write engine: ACTIVE, WRITE with auto-precharge, then a completion pulse.
// Optional macro SDRAM_WRITE_BYTE_MASK_EN adds a per-byte write enable (ibyte_en).
module sdram_write
  import sdram_pkg::*;
#(
  parameter int T_RCD   = 3,
  parameter int T_WR_RP = 4
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        ireq,
  input  logic        ienb,
  output logic        ofin,
  input  logic [12:0] irow,
  input  logic [9:0]  icolumn,
  input  logic [1:0]  ibank,
  input  logic [15:0] idata,
`ifdef SDRAM_WRITE_BYTE_MASK_EN
  input  logic [1:0]  ibyte_en,
`endif
  output logic        DRAM_CLK,
  output logic        DRAM_CKE,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  inout  wire  [15:0] DRAM_DQ
);

  // WAIT_RCD spends load+1 cycles, WAIT_WR spends load+1 cycles.
  localparam logic [3:0] RCD_LOAD = (T_RCD > 1) ? 4'(T_RCD - 2) : 4'd0;
  localparam logic [3:0] WR_LOAD  = 4'(T_WR_RP - 1);

  state_t      state, state_next;
  logic [12:0] row_r;
  logic [9:0]  col_r;
  logic [1:0]  bank_r;
  logic [15:0] data_r;
  logic [1:0]  wr_dqm;
  logic        cnt_load, cnt_tc;
  logic [3:0]  cnt_value;
  cmd_t        cmd;
  logic [12:0] addr;
  logic [1:0]  ba, dqm;
  logic        dq_oe;

`ifdef SDRAM_WRITE_BYTE_MASK_EN
  logic [1:0] byte_en_r;

  // Byte enables are captured with the rest of the request.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      byte_en_r <= 2'b00;
    end else if (state == IDLE && ireq) begin
      byte_en_r <= ibyte_en;
    end else begin
      byte_en_r <= byte_en_r;
    end
  end

  assign wr_dqm = ~byte_en_r;
`else
  assign wr_dqm = 2'b00;
`endif

  sdram_wait_counter u_wait (
    .clk        (iclk),
    .rst_n      (ireset_n),
    .load_value (cnt_value),
    .load       (cnt_load),
    .tc         (cnt_tc)
  );

  // State register.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture; later input changes must not disturb the write in flight.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      row_r  <= 13'd0;
      col_r  <= 10'd0;
      bank_r <= 2'd0;
      data_r <= 16'd0;
    end else if (state == IDLE && ireq) begin
      row_r  <= irow;
      col_r  <= icolumn;
      bank_r <= ibank;
      data_r <= idata;
    end else begin
      row_r  <= row_r;
      col_r  <= col_r;
      bank_r <= bank_r;
      data_r <= data_r;
    end
  end

  // Next-state logic and wait-counter loading on state entry.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_value  = 4'd0;
    case (state)
      IDLE: begin
        if (ireq) begin
          state_next = ACTIVATE;
        end else begin
          state_next = IDLE;
        end
      end
      ACTIVATE: begin
        if (T_RCD > 1) begin
          state_next = WAIT_RCD;
          cnt_load   = 1'b1;
          cnt_value  = RCD_LOAD;
        end else begin
          state_next = WRITE;
        end
      end
      WAIT_RCD: begin
        if (cnt_tc) begin
          state_next = WRITE;
        end else begin
          state_next = WAIT_RCD;
        end
      end
      WRITE: begin
        state_next = WAIT_WR;
        cnt_load   = 1'b1;
        cnt_value  = WR_LOAD;
      end
      WAIT_WR: begin
        if (cnt_tc) begin
          state_next = DONE;
        end else begin
          state_next = WAIT_WR;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus values decoded straight from the state register (NOP unless issuing).
  always_comb begin
    cmd   = CMD_NOP;
    addr  = 13'd0;
    ba    = 2'd0;
    dqm   = 2'b11;
    dq_oe = 1'b0;
    case (state)
      ACTIVATE: begin
        cmd  = CMD_ACTIVE;
        addr = row_r;
        ba   = bank_r;
      end
      WRITE: begin
        cmd   = CMD_WRITE;
        addr  = col_addr_ap(col_r);
        ba    = bank_r;
        dqm   = wr_dqm;
        dq_oe = 1'b1;
      end
      default: begin
        cmd   = CMD_NOP;
        dq_oe = 1'b0;
      end
    endcase
  end

  assign ofin = (state == DONE);

  // Releasing ienb floats the whole SDRAM bus for another master.
  assign DRAM_CLK   = ienb ? ~iclk   : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1    : 1'bz;
  assign DRAM_CS_N  = ienb ? cmd[3]  : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd[2]  : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd[1]  : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd[0]  : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm[1]  : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm[0]  : 1'bz;
  assign DRAM_ADDR  = ienb ? addr    : 13'bz;
  assign DRAM_BA    = ienb ? ba      : 2'bz;
  assign DRAM_DQ    = (ienb && dq_oe) ? data_r : 16'bz;

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write; bus nets carry pull-ups so a floating output reads as all ones.
module tb_sdram_write;

  logic        clk = 1'b0;
  logic        rst_n, req, req_f, enb;
  logic [12:0] row;
  logic [9:0]  col;
  logic [1:0]  bank;
  logic [15:0] data;
  logic [1:0]  byte_en;
  int          checks, failures;

  wire        fin, d_clk, d_cke, d_cs, d_ras, d_cas, d_we, d_ldqm, d_udqm;
  wire [12:0] d_addr;
  wire [1:0]  d_ba;
  wire [15:0] d_dq;
  wire        fin_f, f_clk, f_cke, f_cs, f_ras, f_cas, f_we, f_ldqm, f_udqm;
  wire [12:0] f_addr;
  wire [1:0]  f_ba;
  wire [15:0] f_dq;

  pullup (d_clk);  pullup (d_cke);  pullup (d_cs);   pullup (d_ras);
  pullup (d_cas);  pullup (d_we);   pullup (d_ldqm); pullup (d_udqm);
  pullup (d_addr); pullup (d_ba);   pullup (d_dq);
  pullup (f_dq);

  always #5 clk = ~clk;

  sdram_write dut (
    .iclk(clk), .ireset_n(rst_n), .ireq(req), .ienb(enb), .ofin(fin),
    .irow(row), .icolumn(col), .ibank(bank), .idata(data),
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    .ibyte_en(byte_en),
`endif
    .DRAM_CLK(d_clk), .DRAM_CKE(d_cke), .DRAM_CS_N(d_cs), .DRAM_RAS_N(d_ras),
    .DRAM_CAS_N(d_cas), .DRAM_WE_N(d_we), .DRAM_LDQM(d_ldqm), .DRAM_UDQM(d_udqm),
    .DRAM_ADDR(d_addr), .DRAM_BA(d_ba), .DRAM_DQ(d_dq)
  );

  sdram_write #(.T_RCD(1), .T_WR_RP(1)) dut_fast (
    .iclk(clk), .ireset_n(rst_n), .ireq(req_f), .ienb(1'b1), .ofin(fin_f),
    .irow(row), .icolumn(col), .ibank(bank), .idata(data),
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    .ibyte_en(byte_en),
`endif
    .DRAM_CLK(f_clk), .DRAM_CKE(f_cke), .DRAM_CS_N(f_cs), .DRAM_RAS_N(f_ras),
    .DRAM_CAS_N(f_cas), .DRAM_WE_N(f_we), .DRAM_LDQM(f_ldqm), .DRAM_UDQM(f_udqm),
    .DRAM_ADDR(f_addr), .DRAM_BA(f_ba), .DRAM_DQ(f_dq)
  );

  wire [39:0] obs = {d_cs, d_ras, d_cas, d_we, d_addr, d_ba, d_udqm, d_ldqm, d_dq, fin, d_clk, d_cke};

  // Expected main-DUT bus sample: phase 0 = NOP, 1 = ACTIVE, 2 = WRITE; DRAM_CLK low after posedge.
  function automatic logic [39:0] expv(input int phase, input logic f,
                                       input logic [12:0] r, input logic [9:0] c,
                                       input logic [1:0] b, input logic [15:0] d);
    logic [12:0] wa;
    wa = {2'b00, 1'b1, c};
    if (phase == 1) return {4'b0011, r, b, 2'b11, 16'hFFFF, f, 1'b0, 1'b1};
    if (phase == 2) return {4'b0100, wa, b, 2'b00, d, f, 1'b0, 1'b1};
    return {4'b0111, 13'd0, 2'd0, 2'b11, 16'hFFFF, f, 1'b0, 1'b1};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [39:0] e;
    rst_n = 1'b0;
    tick();
    tick();
    e = expv(0, 1'b0, 13'd0, 10'd0, 2'd0, 16'd0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, e);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [39:0] e;
    row = 13'h1A5; col = 10'h02F; bank = 2'd2; data = 16'hBEEF;
    req = 1'b1;
    tick();
    req = 1'b0;
    row = 13'h000; col = 10'h000; bank = 2'd0; data = 16'h1234;
    for (int k = 0; k <= 10; k++) begin
      e = expv((k == 0) ? 1 : (k == 3) ? 2 : 0, (k == 8), 13'h1A5, 10'h02F, 2'd2, 16'hBEEF);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL basic cycle N+%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_fast;
    logic [3:0]  cmd, ecmd;
    logic [15:0] edq;
    row = 13'h0AA; col = 10'h011; bank = 2'd1; data = 16'hC0DE;
    req_f = 1'b1;
    tick();
    req_f = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      cmd  = {f_cs, f_ras, f_cas, f_we};
      ecmd = (k == 0) ? 4'b0011 : (k == 1) ? 4'b0100 : 4'b0111;
      edq  = (k == 1) ? 16'hC0DE : 16'hFFFF;
      checks++;
      if ({cmd, f_dq, fin_f} !== {ecmd, edq, (k == 3)}) begin
        failures++;
        $display("FAIL fast cycle N+%0d got cmd=%b dq=%h fin=%b exp cmd=%b dq=%h fin=%b",
                 k, cmd, f_dq, fin_f, ecmd, edq, (k == 3));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [39:0] e;
    row = 13'h0F0; col = 10'h155; bank = 2'd1; data = 16'hA5A5;
    req = 1'b1;
    tick();
    for (int k = 0; k <= 30; k++) begin
      e = expv(((k % 10) == 0) ? 1 : ((k % 10) == 3) ? 2 : 0, ((k % 10) == 8),
               13'h0F0, 10'h155, 2'd1, 16'hA5A5);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back cycle N+%0d got=%h exp=%h", k, obs, e);
      end
      if (k == 30) req = 1'b0;
      tick();
    end
    repeat (12) tick();
  endtask

  task automatic test_reset_abort;
    logic [39:0] e;
    row = 13'h077; col = 10'h0CC; bank = 2'd3; data = 16'h5555;
    req = 1'b1;
    tick();
    req = 1'b0;
    e = expv(1, 1'b0, 13'h077, 10'h0CC, 2'd3, 16'h5555);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_active got=%h exp=%h", obs, e);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    e = expv(0, 1'b0, 13'd0, 10'd0, 2'd0, 16'd0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_immediate got=%h exp=%h", obs, e);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort_quiet cycle %0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
    row = 13'h1FFF; col = 10'h3FF; bank = 2'd3; data = 16'h0001;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      e = expv((k == 0) ? 1 : (k == 3) ? 2 : 0, (k == 8), 13'h1FFF, 10'h3FF, 2'd3, 16'h0001);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL after_reset cycle N+%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_no_enable;
    logic [38:0] bus;
    row = 13'h123; col = 10'h045; bank = 2'd0; data = 16'h0000;
    enb = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      bus = {d_cs, d_ras, d_cas, d_we, d_addr, d_ba, d_udqm, d_ldqm, d_dq, d_clk, d_cke};
      checks++;
      if ({bus, fin} !== {{39{1'b1}}, (k == 8)}) begin
        failures++;
        $display("FAIL no_enable cycle N+%0d got bus=%h fin=%b exp bus=all-z fin=%b",
                 k, bus, fin, (k == 8));
      end
      tick();
    end
    enb = 1'b1;
    tick();
  endtask

`ifdef SDRAM_WRITE_BYTE_MASK_EN
  task automatic test_byte_mask;
    logic [1:0] dqm, edqm;
    byte_en = 2'b01;
    req = 1'b1;
    tick();
    req = 1'b0;
    byte_en = 2'b11;
    for (int k = 0; k <= 9; k++) begin
      dqm  = {d_udqm, d_ldqm};
      edqm = (k == 3) ? 2'b10 : 2'b11;
      checks++;
      if (dqm !== edqm) begin
        failures++;
        $display("FAIL byte_mask cycle N+%0d got=%b exp=%b", k, dqm, edqm);
      end
      tick();
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req = 1'b0; req_f = 1'b0; enb = 1'b1;
    row = 13'd0; col = 10'd0; bank = 2'd0; data = 16'd0; byte_en = 2'b11;
    test_reset();
    test_basic();
    test_fast();
    test_back_to_back();
    test_reset_abort();
    test_no_enable();
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    test_byte_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
